// File: rtl/kd_tree_host.sv
// Host controller for the kd_tree node array: resets the tree, streams the centers into the
// root node, starts sorting and waits for completion, bounding every wait with a timeout.
module kd_tree_host #(
  parameter int unsigned CMD_W       = 5,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned NUM_CENTERS = 7,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             in_ready,
  input  logic [CMD_W-1:0]                 root_cmd_up,
  output logic [CMD_W-1:0]                 root_cmd,
  output logic [DATA_W-1:0]                root_data,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [$clog2(NUM_CENTERS+1)-1:0] loaded
);

  localparam int unsigned LoadW  = $clog2(NUM_CENTERS + 1);
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  localparam logic [CMD_W-1:0] CmdNop       = CMD_W'('h00);
  localparam logic [CMD_W-1:0] CmdRst       = CMD_W'('h1F);
  localparam logic [CMD_W-1:0] CmdRstDone   = CMD_W'('h1E);
  localparam logic [CMD_W-1:0] CmdFill      = CMD_W'('h01);
  localparam logic [CMD_W-1:0] CmdFillDone  = CMD_W'('h05);
  localparam logic [CMD_W-1:0] CmdStartSort = CMD_W'('h09);
  localparam logic [CMD_W-1:0] CmdValidSort = CMD_W'('h0F);

  localparam logic [LoadW-1:0]  LoadLast = LoadW'(NUM_CENTERS - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StFill,
    StFillWait,
    StSortStart,
    StSortWait,
    StDone,
    StErr
  } state_e;

  state_e              state_q;
  logic [CMD_W-1:0]    root_cmd_q;
  logic [DATA_W-1:0]   root_data_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [LoadW-1:0]    loaded_q;
  logic [TimerW-1:0]   timer_q;
  logic                accept;
  logic                timed_out;

  assign accept    = in_valid & in_ready_q;
  assign timed_out = (timer_q == TimerMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      root_cmd_q  <= CmdNop;
      root_data_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      loaded_q    <= '0;
      timer_q     <= '0;
    end else begin
      root_cmd_q <= CmdNop;
      done_q     <= 1'b0;
      // abort in IDLE also suppresses a simultaneous start
      if (abort) begin
        state_q    <= StIdle;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
        timer_q    <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q    <= StRst;
              root_cmd_q <= CmdRst;
              busy_q     <= 1'b1;
              error_q    <= 1'b0;
              loaded_q   <= '0;
              timer_q    <= '0;
            end
          end
          StRst: begin
            if (timed_out) begin
              state_q <= StErr;
              error_q <= 1'b1;
              timer_q <= '0;
            end else if (root_cmd_up == CmdRstDone) begin
              state_q    <= StFill;
              in_ready_q <= 1'b1;
              timer_q    <= '0;
            end else begin
              root_cmd_q <= CmdRst;
              timer_q    <= timer_q + 1'b1;
            end
          end
          StFill: begin
            // fill_done can only be premature here: the last accept leaves FILL
            if (root_cmd_up == CmdFillDone) begin
              state_q    <= StErr;
              error_q    <= 1'b1;
              in_ready_q <= 1'b0;
              timer_q    <= '0;
            end else if (accept) begin
              root_cmd_q  <= CmdFill;
              root_data_q <= in_data;
              loaded_q    <= loaded_q + 1'b1;
              timer_q     <= '0;
              if (loaded_q == LoadLast) begin
                state_q    <= StFillWait;
                in_ready_q <= 1'b0;
              end
            end else if (timed_out) begin
              state_q    <= StErr;
              error_q    <= 1'b1;
              in_ready_q <= 1'b0;
              timer_q    <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StFillWait: begin
            if (timed_out) begin
              state_q <= StErr;
              error_q <= 1'b1;
              timer_q <= '0;
            end else if (root_cmd_up == CmdFillDone) begin
              state_q     <= StSortStart;
              root_cmd_q  <= CmdStartSort;
              root_data_q <= '0;
              timer_q     <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StSortStart: begin
            state_q <= StSortWait;
            timer_q <= '0;
          end
          StSortWait: begin
            if (timed_out) begin
              state_q <= StErr;
              error_q <= 1'b1;
              timer_q <= '0;
            end else if (root_cmd_up == CmdValidSort) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StDone, StErr: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            timer_q <= '0;
          end
          default: begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            timer_q    <= '0;
          end
        endcase
      end
    end
  end

  assign root_cmd  = root_cmd_q;
  assign root_data = root_data_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign loaded    = loaded_q;

endmodule

// File: tb/tb_kd_tree_host.sv
// Directed bench for kd_tree_host; drives the root node's upward command by hand.
module tb_kd_tree_host;

  logic        clk = 1'b0;
  logic        reset, start, abort, in_valid;
  logic [23:0] in_data;
  logic        in_ready;
  logic [4:0]  root_cmd_up, root_cmd;
  logic [23:0] root_data;
  logic        busy, done, error;
  logic [2:0]  loaded;

  int checks = 0;
  int errors = 0;

  kd_tree_host #(
    .CMD_W(5), .DATA_W(24), .NUM_CENTERS(7), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .root_cmd_up(root_cmd_up), .root_cmd(root_cmd), .root_data(root_data),
    .busy(busy), .done(done), .error(error), .loaded(loaded)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // start, three RST cycles, rst_done -> sitting in FILL with nothing accepted
  task automatic go_fill();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    root_cmd_up = 5'h1E; tick(); root_cmd_up = 5'h00;
  endtask

  task automatic feed7(input logic [23:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = base + 24'(i); tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic to_sort_wait();
    go_fill();
    feed7(24'h000100);
    root_cmd_up = 5'h05; tick();
    root_cmd_up = 5'h00; tick();
  endtask

  int          fills;
  int          dones;
  logic [23:0] last_data;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = '0; root_cmd_up = 5'h00;
    tick(); tick();
    chk("rst_cmd", 32'(root_cmd), 32'h00);
    chk("rst_data", 32'(root_data), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_loaded", 32'(loaded), 32'h0);
    reset = 1'b0;

    // 1. nominal run
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_rst_cmd0", 32'(root_cmd), 32'h1F);
    chk("t1_busy", 32'(busy), 32'h1);
    tick(); chk("t1_rst_cmd1", 32'(root_cmd), 32'h1F);
    tick(); chk("t1_rst_cmd2", 32'(root_cmd), 32'h1F);
    root_cmd_up = 5'h1E; tick(); root_cmd_up = 5'h00;
    chk("t1_fill_nop", 32'(root_cmd), 32'h00);
    chk("t1_fill_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      in_data = 24'(i); tick();
      chk("t1_fill_cmd", 32'(root_cmd), 32'h01);
      chk("t1_fill_data", 32'(root_data), i);
      chk("t1_loaded", 32'(loaded), i);
      chk("t1_ready", 32'(in_ready), (i == 7) ? 32'h0 : 32'h1);
    end
    in_valid = 1'b0;
    tick(); chk("t1_fwait_cmd", 32'(root_cmd), 32'h00);
    root_cmd_up = 5'h05; tick(); root_cmd_up = 5'h00;
    chk("t1_sort_cmd", 32'(root_cmd), 32'h09);
    chk("t1_sort_data", 32'(root_data), 32'h0);
    tick(); chk("t1_swait_cmd", 32'(root_cmd), 32'h00);
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      tick(); if (done) dones++;
    end
    chk("t1_no_early_done", 32'(dones), 32'h0);
    root_cmd_up = 5'h0F; tick(); root_cmd_up = 5'h00;
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_done_busy", 32'(busy), 32'h1);
    tick();
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_final_loaded", 32'(loaded), 32'h7);
    chk("t1_final_error", 32'(error), 32'h0);

    // 2. in_valid toggling: nops between fills, data held
    go_fill();
    fills = 0; last_data = 24'h000007;
    for (int k = 0; k < 14; k++) begin
      in_valid = (k % 2 == 0); in_data = 24'h000010 + 24'(k); tick();
      if (k % 2 == 0) begin
        chk("t2_fill_cmd", 32'(root_cmd), 32'h01);
        chk("t2_fill_data", 32'(root_data), 32'h10 + k);
        last_data = 24'h000010 + 24'(k);
      end else begin
        chk("t2_gap_cmd", 32'(root_cmd), 32'h00);
        chk("t2_gap_data", 32'(root_data), 32'(last_data));
      end
      if (root_cmd == 5'h01) fills++;
    end
    in_valid = 1'b0;
    chk("t2_fill_count", 32'(fills), 32'h7);
    chk("t2_loaded", 32'(loaded), 32'h7);
    chk("t2_ready_off", 32'(in_ready), 32'h0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t2_abort_busy", 32'(busy), 32'h0);

    // 3. timeout in RST with TIMEOUT=15
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t3_pre_err", 32'(error), 32'h0);
    chk("t3_pre_cmd", 32'(root_cmd), 32'h1F);
    tick();
    chk("t3_err", 32'(error), 32'h1);
    chk("t3_err_cmd", 32'(root_cmd), 32'h00);
    tick();
    chk("t3_idle_busy", 32'(busy), 32'h0);
    chk("t3_sticky", 32'(error), 32'h1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_err_clr", 32'(error), 32'h0);
    chk("t3_restart_cmd", 32'(root_cmd), 32'h1F);
    abort = 1'b1; tick(); abort = 1'b0;

    // 4. premature center_fill_done after 3 accepts
    go_fill();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 24'h0000A1 + 24'(i); tick();
    end
    in_valid = 1'b0;
    root_cmd_up = 5'h05; tick(); root_cmd_up = 5'h00;
    chk("t4_err", 32'(error), 32'h1);
    chk("t4_ready", 32'(in_ready), 32'h0);
    chk("t4_loaded", 32'(loaded), 32'h3);
    tick();
    chk("t4_idle", 32'(busy), 32'h0);

    // 5. abort in SORT_WAIT with start, abort+start in IDLE, reset mid-FILL
    to_sort_wait();
    chk("t5_err_clr", 32'(error), 32'h0);
    abort = 1'b1; start = 1'b1; tick();
    chk("t5_abort_busy", 32'(busy), 32'h0);
    chk("t5_abort_cmd", 32'(root_cmd), 32'h00);
    chk("t5_abort_done", 32'(done), 32'h0);
    tick();
    chk("t5_idle_start_busy", 32'(busy), 32'h0);
    chk("t5_idle_start_cmd", 32'(root_cmd), 32'h00);
    abort = 1'b0; start = 1'b0;
    go_fill();
    in_valid = 1'b1; in_data = 24'h00BEEF; tick(); tick(); in_valid = 1'b0;
    chk("t5_pre_reset_loaded", 32'(loaded), 32'h2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_reset_cmd", 32'(root_cmd), 32'h00);
    chk("t5_reset_ready", 32'(in_ready), 32'h0);
    chk("t5_reset_busy", 32'(busy), 32'h0);
    chk("t5_reset_loaded", 32'(loaded), 32'h0);
    chk("t5_reset_data", 32'(root_data), 32'h0);
    tick();
    chk("t5_no_auto_rst", 32'(root_cmd), 32'h00);

    // 6. start during SORT_WAIT ignored, single done
    to_sort_wait();
    start = 1'b1; tick(); tick(); start = 1'b0;
    chk("t6_still_busy", 32'(busy), 32'h1);
    chk("t6_swait_cmd", 32'(root_cmd), 32'h00);
    root_cmd_up = 5'h0F; dones = 0;
    tick(); if (done) dones++;
    root_cmd_up = 5'h00;
    for (int i = 0; i < 6; i++) begin
      tick(); if (done) dones++;
    end
    chk("t6_one_done", 32'(dones), 32'h1);
    chk("t6_idle", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
